// File: rtl/intersection_pkg.sv
`default_nettype none
// ============================================================================
// Module      : intersection_pkg
// Description : Shared light codes, phase encoding and default phase timing
//               for the intersection controllers.
// Revision    : 1.0 - initial release
// ============================================================================
package intersection_pkg;

    localparam logic [1:0] c_light_off    = 2'd0;
    localparam logic [1:0] c_light_green  = 2'd1;
    localparam logic [1:0] c_light_yellow = 2'd2;
    localparam logic [1:0] c_light_red    = 2'd3;

    typedef enum logic [2:0] {
        MAIN_G = 3'd0,
        MAIN_Y = 3'd1,
        CLR_S  = 3'd2,
        SIDE_G = 3'd3,
        SIDE_Y = 3'd4,
        CLR_M  = 3'd5,
        WALK   = 3'd6,
        EMERG  = 3'd7
    } phase_e;

    // Default durations, in ticks
    localparam int c_t_main_min = 6;
    localparam int c_t_side     = 6;
    localparam int c_t_ext      = 3;
    localparam int c_t_yel      = 2;
    localparam int c_t_clr      = 1;
    localparam int c_t_walk     = 4;

endpackage : intersection_pkg
`default_nettype wire

// File: rtl/phase_timer.sv
`default_nettype none
// ============================================================================
// Module      : phase_timer
// Description : Tick-gated 5-bit phase counter with synchronous clear,
//               saturation at full scale and a tick-qualified expire flag.
// Revision    : 1.0 - initial release
// ============================================================================
module phase_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       clear,
    input  logic [4:0] limit,
    output logic [4:0] cnt,
    output logic       expire
);

    logic [4:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= 5'd0;
        end else if (clear) begin
            r_cnt <= 5'd0;
        end else if (tick && (r_cnt != 5'h1F)) begin
            r_cnt <= r_cnt + 5'd1;
        end
    end

    assign cnt    = r_cnt;
    assign expire = tick && (r_cnt == (limit - 5'd1));

endmodule : phase_timer
`default_nettype wire

// File: rtl/intersection_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : intersection_scheduler
// Description : Actuated main/side/pedestrian phase scheduler with emergency
//               preempt; light outputs registered from the next phase.
// Revision    : 1.0 - initial release
// ============================================================================
module intersection_scheduler
    import intersection_pkg::*;
#(
    parameter int T_MAIN_MIN = c_t_main_min,
    parameter int T_SIDE     = c_t_side,
    parameter int T_EXT      = c_t_ext,
    parameter int T_YEL      = c_t_yel,
    parameter int T_CLR      = c_t_clr,
    parameter int T_WALK     = c_t_walk
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       sensor,
    input  logic       walk_btn,
    input  logic       emerg,
    output logic [1:0] main_light,
    output logic [1:0] side_light,
    output logic       walk_light,
    output logic [2:0] phase
);

    localparam logic [4:0] c_lim_main  = 5'(T_MAIN_MIN);
    localparam logic [4:0] c_lim_side  = 5'(T_SIDE);
    localparam logic [4:0] c_lim_ext   = 5'(T_SIDE + T_EXT);
    localparam logic [4:0] c_lim_yel   = 5'(T_YEL);
    localparam logic [4:0] c_lim_clr   = 5'(T_CLR);
    localparam logic [4:0] c_lim_walk  = 5'(T_WALK);
    localparam logic [4:0] c_main_last = 5'(T_MAIN_MIN - 1);
    localparam logic [4:0] c_side_last = 5'(T_SIDE - 1);

    phase_e     r_state;
    phase_e     w_state_nxt;
    logic       r_walk_req;
    logic       r_side_req;
    logic       r_emerg_pend;
    logic       r_ext_used;
    logic [1:0] r_main_light;
    logic [1:0] r_side_light;
    logic       r_walk_light;
    logic [1:0] w_main_light;
    logic [1:0] w_side_light;
    logic       w_walk_light;
    logic [4:0] w_cnt;
    logic [4:0] w_limit;
    logic       w_expire;
    logic       w_preempt;
    logic       w_extend;
    logic       w_change;

    assign w_preempt = emerg | r_emerg_pend;
    assign w_change  = (w_state_nxt != r_state);
    // Sensor still present at the base side-green end buys one extension
    assign w_extend  = tick && (r_state == SIDE_G) && (w_cnt == c_side_last)
                       && sensor && !r_ext_used;

    always_comb begin
        w_limit = 5'h1F;
        case (r_state)
            MAIN_G:        w_limit = c_lim_main;
            MAIN_Y,
            SIDE_Y:        w_limit = c_lim_yel;
            CLR_S,
            CLR_M:         w_limit = c_lim_clr;
            SIDE_G:        w_limit = r_ext_used ? c_lim_ext : c_lim_side;
            WALK:          w_limit = c_lim_walk;
            default:       w_limit = 5'h1F;
        endcase
    end

    phase_timer u_phase_timer (
        .clk    (clk),
        .reset  (reset),
        .tick   (tick),
        .clear  (w_change),
        .limit  (w_limit),
        .cnt    (w_cnt),
        .expire (w_expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= MAIN_G;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (tick) begin
            case (r_state)
                MAIN_G: begin
                    if (w_preempt) begin
                        w_state_nxt = MAIN_Y;
                    end else if ((w_cnt >= c_main_last) && (r_walk_req || r_side_req)) begin
                        w_state_nxt = MAIN_Y;
                    end
                end
                MAIN_Y: if (w_expire) w_state_nxt = CLR_S;
                CLR_S: begin
                    if (w_expire) begin
                        if (r_emerg_pend)    w_state_nxt = EMERG;
                        else if (r_walk_req) w_state_nxt = WALK;
                        else if (r_side_req) w_state_nxt = SIDE_G;
                        else                 w_state_nxt = MAIN_G;
                    end
                end
                SIDE_G: begin
                    if (w_preempt || (w_expire && !w_extend)) w_state_nxt = SIDE_Y;
                end
                SIDE_Y: if (w_expire) w_state_nxt = CLR_M;
                WALK: begin
                    if (w_preempt)     w_state_nxt = CLR_M;
                    else if (w_expire) w_state_nxt = MAIN_G;
                end
                CLR_M: if (w_expire) w_state_nxt = r_emerg_pend ? EMERG : MAIN_G;
                EMERG: if (!emerg) w_state_nxt = CLR_M;
                default: w_state_nxt = MAIN_G;
            endcase
        end
    end

    // Clearing on phase entry takes priority over a same-cycle request
    always_ff @(posedge clk) begin
        if (reset) begin
            r_walk_req   <= 1'b0;
            r_side_req   <= 1'b0;
            r_emerg_pend <= 1'b0;
            r_ext_used   <= 1'b0;
        end else begin
            if (w_change && (w_state_nxt == WALK))     r_walk_req <= 1'b0;
            else if (walk_btn && (r_state != WALK))    r_walk_req <= 1'b1;

            if (w_change && (w_state_nxt == SIDE_G))   r_side_req <= 1'b0;
            else if (sensor && (r_state != SIDE_G))    r_side_req <= 1'b1;

            if ((r_state == EMERG) && w_change)        r_emerg_pend <= 1'b0;
            else if (emerg && (r_state != EMERG))      r_emerg_pend <= 1'b1;

            if (w_change && (w_state_nxt == SIDE_G))   r_ext_used <= 1'b0;
            else if (w_extend && !w_change)            r_ext_used <= 1'b1;
        end
    end

    always_comb begin
        w_main_light = c_light_red;
        w_side_light = c_light_red;
        w_walk_light = 1'b0;
        case (w_state_nxt)
            MAIN_G:  w_main_light = c_light_green;
            MAIN_Y:  w_main_light = c_light_yellow;
            SIDE_G:  w_side_light = c_light_green;
            SIDE_Y:  w_side_light = c_light_yellow;
            WALK:    w_walk_light = 1'b1;
            CLR_S,
            CLR_M,
            EMERG:   w_walk_light = 1'b0;
            default: begin
                w_main_light = c_light_off;
                w_side_light = c_light_off;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_main_light <= c_light_green;
            r_side_light <= c_light_red;
            r_walk_light <= 1'b0;
        end else begin
            r_main_light <= w_main_light;
            r_side_light <= w_side_light;
            r_walk_light <= w_walk_light;
        end
    end

    assign main_light = r_main_light;
    assign side_light = r_side_light;
    assign walk_light = r_walk_light;
    assign phase      = r_state;

endmodule : intersection_scheduler
`default_nettype wire

// File: tb/tb_intersection_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_intersection_scheduler
// Description : Directed self-checking bench for intersection_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_intersection_scheduler;

    logic       clk;
    logic       reset;
    logic       tick;
    logic       sensor;
    logic       walk_btn;
    logic       emerg;
    logic [1:0] main_light;
    logic [1:0] side_light;
    logic       walk_light;
    logic [2:0] phase;

    int n_vec = 0;
    int n_err = 0;

    intersection_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .sensor     (sensor),
        .walk_btn   (walk_btn),
        .emerg      (emerg),
        .main_light (main_light),
        .side_light (side_light),
        .walk_light (walk_light),
        .phase      (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Hand-derived phase for each scenario and cycle after reset release
    function automatic int exp_phase(int sc, int c);
        case (sc)
            1: begin
                if (c <= 5)  return 0;
                if (c <= 7)  return 1;
                if (c == 8)  return 2;
                if (c <= 14) return 3;
                if (c <= 16) return 4;
                if (c == 17) return 5;
                return 0;
            end
            2: begin
                if (c <= 5)  return 0;
                if (c <= 7)  return 1;
                if (c == 8)  return 2;
                if (c <= 17) return 3;
                if (c <= 19) return 4;
                if (c == 20) return 5;
                return 0;
            end
            3, 5: begin
                if (sc == 5 && c >= 11) return 0;
                if (c <= 5)  return 0;
                if (c <= 7)  return 1;
                if (c == 8)  return 2;
                if (c <= 12) return 6;
                if (c <= 18) return 0;
                if (c <= 20) return 1;
                if (c == 21) return 2;
                if (c <= 27) return 3;
                if (c <= 29) return 4;
                if (c == 30) return 5;
                return 0;
            end
            4: begin
                if (c <= 5)  return 0;
                if (c <= 7)  return 1;
                if (c == 8)  return 2;
                if (c <= 10) return 3;
                if (c <= 12) return 4;
                if (c == 13) return 5;
                if (c <= 30) return 7;
                if (c == 31) return 5;
                return 0;
            end
            6: begin
                if (c <= 4) return 0;
                if (c <= 6) return 1;
                if (c == 7) return 2;
                if (c == 8) return 7;
                if (c == 9) return 5;
                return 0;
            end
            default: return 0;
        endcase
    endfunction

    task automatic run_scenario(input int sc, input int ncyc);
        int ep;
        int em;
        int es;
        reset    = 1'b1;
        tick     = 1'b1;
        sensor   = 1'b0;
        walk_btn = 1'b0;
        emerg    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            tick     = (sc == 6) ? (c != 3) : 1'b1;
            reset    = (sc == 5) && (c == 10);
            sensor   = ((sc == 1 || sc == 4) && c == 2) ||
                       (sc == 2 && c >= 2 && c <= 17) ||
                       ((sc == 3 || sc == 5) && c == 1);
            walk_btn = (sc == 3 || sc == 5) && (c == 1);
            emerg    = (sc == 4 && c >= 10 && c <= 29) || (sc == 6 && c == 3);
            @(negedge clk);
            ep = exp_phase(sc, c);
            em = (ep == 0) ? 1 : (ep == 1) ? 2 : 3;
            es = (ep == 3) ? 1 : (ep == 4) ? 2 : 3;
            check($sformatf("sc%0d cyc%0d phase", sc, c), 32'(phase), 32'(ep));
            check($sformatf("sc%0d cyc%0d main_light", sc, c), 32'(main_light), 32'(em));
            check($sformatf("sc%0d cyc%0d side_light", sc, c), 32'(side_light), 32'(es));
            check($sformatf("sc%0d cyc%0d walk_light", sc, c), 32'(walk_light), 32'(ep == 6));
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset    = 1'b1;
        tick     = 1'b0;
        sensor   = 1'b0;
        walk_btn = 1'b0;
        emerg    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset phase", 32'(phase), 32'd0);
        check("reset main_light", 32'(main_light), 32'd1);
        check("reset side_light", 32'(side_light), 32'd3);
        check("reset walk_light", 32'(walk_light), 32'd0);

        run_scenario(0, 30);   // no requests: main rests
        run_scenario(1, 22);   // sensor pulse
        run_scenario(2, 21);   // sensor held: one extension
        run_scenario(3, 34);   // walk + sensor pulse together
        run_scenario(4, 36);   // emergency during side green
        run_scenario(5, 30);   // reset mid-walk discards side request
        run_scenario(6, 14);   // emergency pulse while tick is low

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_intersection_scheduler
`default_nettype wire
